sp_lutram: RTL and testbench
============================

Name: sp_lutram

Overview:
Single-port, byte-maskable RAM of NUM_SET entries, each SINGLE_ENTRY_SIZE_IN_BITS wide, intended for LUT/distributed-RAM mapping. Used as generic small storage (tags, metadata, small buffers) in the common basic_storage library. One shared address for read and write; the read data is registered.

Parameters:
SINGLE_ENTRY_SIZE_IN_BITS, 64, entry width in bits; must be a multiple of 8.
NUM_SET, 64, number of entries.
SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width.
WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS/8, number of byte write enables (byte = `BYTE_LEN_IN_BITS = 8).

Ports:
clk_in  input  1  clock; all state updates on the rising edge.
reset_in  input  1  synchronous, active-high reset.
access_en_in  input  1  port enable; no read or write occurs when low.
write_en_in  input  WRITE_MASK_LEN  per-byte write enable; bit i covers entry bits [8i+7:8i].
access_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  entry index for read and write.
write_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data.
read_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  registered read data.

Behaviour:
- Reset (reset_in=1 at a rising edge): every entry cleared to 0; read_entry_out cleared to 0. Reset has priority over any access in the same cycle; an in-flight access is discarded.
- Write: at a rising edge with access_en_in=1 and write_en_in[i]=1, byte i of entry[access_set_addr_in] takes byte i of write_entry_in. Bytes with write_en_in[i]=0 keep their value. Partial masks are legal.
- Read: at every rising edge with access_en_in=1, read_entry_out is loaded with entry[access_set_addr_in].
- Read latency is 1 cycle. Address and enable sampled at edge N give data valid after edge N, stable until the next enabled edge.
- Read-during-write, same cycle: read-first. read_entry_out shows the entry's pre-write contents. New data is visible on the next enabled read of that address.
- access_en_in=0: memory and read_entry_out hold their values; write_en_in is ignored.
- write_en_in=0 with access_en_in=1 is a pure read; memory is unchanged regardless of write_entry_in.
- Address range: addresses 0..NUM_SET-1 are valid. If NUM_SET is not a power of 2, an out-of-range address makes writes no-ops and reads return 0.
- No X is ever driven on read_entry_out after the first reset.

Test Plan:
- Reset: assert reset_in for 1 cycle with access_en_in=1 and write_en_in=all ones -> read_entry_out=0. A subsequent read of addresses 0 and 63 returns 0.
- Basic write-read: write 0xFFFFFFFF00000000 with full mask to address 63. Read address 63 with write_en_in=0 -> read_entry_out=0xFFFFFFFF00000000 one cycle later, not X.
- Write-enable gating: with write_en_in=0, access_en_in=1, address 63 and write_entry_in=0x00000000FFFFFFFF -> read still returns 0xFFFFFFFF00000000.
- Byte mask: address 5 holds 0x1111111111111111. Write 0xAAAAAAAAAAAAAAAA with mask 0x0F -> readback 0x11111111AAAAAAAA.
- Read-first and port disable:
  - Write 0x5 to address 3 whose prior content is 0x9 -> the same-cycle read_entry_out is 0x9; the next read is 0x5.
  - With access_en_in=0, change the address and drive write_en_in=all ones -> read_entry_out and memory are unchanged.
- Address sweep: write each address a with value a*0x0101010101010101, then read all addresses -> each returns its value; addresses 0 and 63 do not alias.

Source files
------------

// File: rtl/sp_lutram_if.sv
// Access port bundle for sp_lutram: shared address, byte-masked write, registered read data.
interface sp_lutram_if #(
    parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int unsigned NUM_SET                   = 64
);
    localparam int unsigned BYTE_LEN_IN_BITS      = 8;
    localparam int unsigned WRITE_MASK_LEN        = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS;
    localparam int unsigned SET_PTR_WIDTH_IN_BITS = (NUM_SET > 1) ? $clog2(NUM_SET) : 1;

    logic                                 access_en_in;
    logic [WRITE_MASK_LEN-1:0]            write_en_in;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_in;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out;

    modport master (
        output access_en_in,
        output write_en_in,
        output access_set_addr_in,
        output write_entry_in,
        input  read_entry_out
    );

    modport slave (
        input  access_en_in,
        input  write_en_in,
        input  access_set_addr_in,
        input  write_entry_in,
        output read_entry_out
    );
endinterface

// File: rtl/sp_lutram.sv
// Single-port byte-maskable RAM for distributed-RAM mapping; read-first, 1-cycle registered read.
module sp_lutram #(
    parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int unsigned NUM_SET                   = 64
) (
    input  logic        clk_in,
    input  logic        reset_in,
    sp_lutram_if.slave  bus
);
    localparam int unsigned BYTE_LEN_IN_BITS      = 8;
    localparam int unsigned WRITE_MASK_LEN        = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS;
    localparam int unsigned SET_PTR_WIDTH_IN_BITS = (NUM_SET > 1) ? $clog2(NUM_SET) : 1;

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_q [NUM_SET];
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_d [NUM_SET];
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rd_q;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rd_d;
    logic                                 addr_valid;

    // Out-of-range addresses (non power-of-2 depth) read as zero and drop writes.
    always_comb begin
        mem_d      = mem_q;
        rd_d       = rd_q;
        addr_valid = (32'(bus.access_set_addr_in) < NUM_SET);
        if (bus.access_en_in) begin
            rd_d = addr_valid ? mem_q[bus.access_set_addr_in] : '0;
            if (addr_valid) begin
                for (int unsigned i = 0; i < WRITE_MASK_LEN; i++) begin
                    if (bus.write_en_in[i]) begin
                        mem_d[bus.access_set_addr_in][i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
                            bus.write_entry_in[i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int unsigned s = 0; s < NUM_SET; s++) begin
                mem_q[s] <= '0;
            end
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign bus.read_entry_out = rd_q;
endmodule

// File: tb/tb_sp_lutram.sv
// Self-checking bench for sp_lutram: directed vector table, hand sequences, random traffic vs array model.
module tb_sp_lutram;
    localparam int unsigned W  = 64;
    localparam int unsigned NS = 64;
    localparam int unsigned ML = W / 8;

    logic clk_in;
    logic reset_in;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] model [NS];
    logic [W-1:0] exp_rd;

    sp_lutram_if #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_SET(NS)) bus ();

    sp_lutram #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_SET(NS)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic          en;
        logic [ML-1:0] we;
        logic [5:0]    addr;
        logic [W-1:0]  wdata;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Model: read-first, byte-masked write, hold when disabled.
    task automatic model_step(input logic en, input logic [ML-1:0] we, input logic [5:0] addr,
                              input logic [W-1:0] wdata);
        if (en) begin
            exp_rd = model[addr];
            for (int b = 0; b < int'(ML); b++)
                if (we[b]) model[addr][b*8 +: 8] = wdata[b*8 +: 8];
        end
    endtask

    task automatic cycle(input logic en, input logic [ML-1:0] we, input logic [5:0] addr,
                         input logic [W-1:0] wdata);
        bus.access_en_in       = en;
        bus.write_en_in        = we;
        bus.access_set_addr_in = addr;
        bus.write_entry_in     = wdata;
        @(posedge clk_in);
        #1;
        model_step(en, we, addr, wdata);
    endtask

    task automatic do_reset(input logic [5:0] addr, input logic [W-1:0] wdata);
        reset_in               = 1'b1;
        bus.access_en_in       = 1'b1;
        bus.write_en_in        = '1;
        bus.access_set_addr_in = addr;
        bus.write_entry_in     = wdata;
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        for (int s = 0; s < int'(NS); s++) model[s] = '0;
        exp_rd = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_in = 1'b0;
        bus.access_en_in       = 1'b0;
        bus.write_en_in        = '0;
        bus.access_set_addr_in = '0;
        bus.write_entry_in     = '0;
        @(posedge clk_in);
        #1;

        do_reset(6'd10, 64'hDEAD_BEEF_CAFE_F00D);
        check("reset_rd", bus.read_entry_out, 64'h0);

        vecs[0]  = '{1'b1, 8'h00, 6'd0,  64'h0,                 64'h0};
        vecs[1]  = '{1'b1, 8'h00, 6'd63, 64'h0,                 64'h0};
        vecs[2]  = '{1'b1, 8'hFF, 6'd63, 64'hFFFFFFFF_00000000, 64'h0};
        vecs[3]  = '{1'b1, 8'h00, 6'd63, 64'h00000000_FFFFFFFF, 64'hFFFFFFFF_00000000};
        vecs[4]  = '{1'b1, 8'h00, 6'd63, 64'h00000000_FFFFFFFF, 64'hFFFFFFFF_00000000};
        vecs[5]  = '{1'b1, 8'hFF, 6'd5,  64'h11111111_11111111, 64'h0};
        vecs[6]  = '{1'b1, 8'h0F, 6'd5,  64'hAAAAAAAA_AAAAAAAA, 64'h11111111_11111111};
        vecs[7]  = '{1'b1, 8'h00, 6'd5,  64'h0,                 64'h11111111_AAAAAAAA};
        vecs[8]  = '{1'b1, 8'hFF, 6'd3,  64'h9,                 64'h0};
        vecs[9]  = '{1'b1, 8'hFF, 6'd3,  64'h5,                 64'h9};
        vecs[10] = '{1'b1, 8'h00, 6'd3,  64'h0,                 64'h5};
        vecs[11] = '{1'b0, 8'hFF, 6'd63, 64'h0,                 64'h5};
        vecs[12] = '{1'b0, 8'hFF, 6'd5,  64'h0,                 64'h5};
        vecs[13] = '{1'b1, 8'h00, 6'd63, 64'h0,                 64'hFFFFFFFF_00000000};
        vecs[14] = '{1'b1, 8'h00, 6'd5,  64'h0,                 64'h11111111_AAAAAAAA};

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d", i), bus.read_entry_out, vecs[i].exp);
        end

        // Address sweep: distinct pattern per entry, then read all back.
        for (int a = 0; a < int'(NS); a++)
            cycle(1'b1, '1, 6'(a), 64'(a) * 64'h01010101_01010101);
        for (int a = 0; a < int'(NS); a++) begin
            cycle(1'b1, '0, 6'(a), 64'hFFFF_FFFF_FFFF_FFFF);
            check($sformatf("sweep%0d", a), bus.read_entry_out, 64'(a) * 64'h01010101_01010101);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic          en;
            logic [ML-1:0] we;
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       we = '0;
                1:       we = '1;
                default: we = ML'($urandom);
            endcase
            cycle(en, we, 6'($urandom_range(0, NS - 1)), {$urandom, $urandom});
            check("rand", bus.read_entry_out, exp_rd);
        end

        // Reset with an in-flight write discards the write and clears storage.
        cycle(1'b1, '0, 6'd7, 64'h0);
        do_reset(6'd7, 64'h1234_5678_9ABC_DEF0);
        check("reset2_rd", bus.read_entry_out, 64'h0);
        cycle(1'b1, '0, 6'd7, 64'h0);
        check("reset2_addr7", bus.read_entry_out, 64'h0);
        cycle(1'b1, '0, 6'd0, 64'h0);
        check("reset2_addr0", bus.read_entry_out, 64'h0);
        cycle(1'b1, '0, 6'd63, 64'h0);
        check("reset2_addr63", bus.read_entry_out, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
